// File: rtl/proc_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_ctrl_if
// Description : Valid/ready state-dump stream from the run controller to its
//               sink.
//               master : drives dump_valid, dump_data, dump_is_mem, dump_idx
//                        and dump_done; samples dump_ready
//               slave  : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_run_ctrl_if #(
    parameter int REG_W = 32,
    parameter int IDX_W = 5
);
    logic             dump_valid;
    logic             dump_ready;
    logic [REG_W-1:0] dump_data;
    logic             dump_is_mem;
    logic [IDX_W-1:0] dump_idx;
    logic             dump_done;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_is_mem,
        output dump_idx,
        output dump_done,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_is_mem,
        input  dump_idx,
        input  dump_done,
        output dump_ready
    );
endinterface
`default_nettype wire

// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_ctrl
// Description : Run control and state dump for the pipelined processor.
//               The unit gates the core with a clock enable. It halts the
//               core on a cycle budget, a PC breakpoint or a single step.
//               After each halt it streams every register-file word and then
//               the low data-memory words out over a valid/ready interface.
// Ports       : clk            - single clock
//               rst_n          - asynchronous active-low reset
//               i_start        - pulse: clear the cycle counter, enter RUN
//               i_step         - pulse: execute exactly one core cycle
//               i_cycle_limit  - halt budget (0 = unlimited), sampled live
//               i_bp_en/i_bp_pc- PC breakpoint enable / address
//               i_pc           - current core PC
//               o_cpu_en       - core advance enable
//               o_rf_raddr / i_rf_rdata - register-file debug read port
//               o_dm_raddr / i_dm_rdata - data-memory debug read port
//               dump           - dump stream (master side)
//               o_cycle_count  - enabled cycles since the last start
//               o_halted       - high in HALT
//               o_halt_cause   - 00 none, 01 limit, 10 breakpoint, 11 step
// Revision    : 1.0 - initial release
// ============================================================================
module proc_run_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int REG_W      = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_WORDS = 8,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_start,
    input  wire logic              i_step,
    input  wire logic [CNT_W-1:0]  i_cycle_limit,
    input  wire logic              i_bp_en,
    input  wire logic [ADDR_W-1:0] i_bp_pc,
    input  wire logic [ADDR_W-1:0] i_pc,
    output logic                   o_cpu_en,
    output logic [IDX_W-1:0]       o_rf_raddr,
    input  wire logic [REG_W-1:0]  i_rf_rdata,
    output logic [IDX_W-1:0]       o_dm_raddr,
    input  wire logic [REG_W-1:0]  i_dm_rdata,
    proc_run_ctrl_if.master        dump,
    output logic [CNT_W-1:0]       o_cycle_count,
    output logic                   o_halted,
    output logic [1:0]             o_halt_cause
);

    localparam logic [IDX_W-1:0] c_RF_LAST  = IDX_W'(NREGS - 1);
    localparam logic [IDX_W-1:0] c_MEM_LAST = IDX_W'(DMEM_WORDS - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    localparam logic [1:0] c_CAUSE_LIMIT = 2'b01;
    localparam logic [1:0] c_CAUSE_BP    = 2'b10;
    localparam logic [1:0] c_CAUSE_STEP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_STEP     = 3'd2,
        S_DUMP_RF  = 3'd3,
        S_DUMP_MEM = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cycle_count;
    logic [IDX_W-1:0] r_dump_idx;
    logic [1:0]       r_halt_cause;
    logic             r_dump_done;
    // Set on the first RUN cycle after entry so that resuming from the
    // breakpoint address executes that instruction instead of re-trapping.
    logic             r_first_run;

    logic             w_start_run;
    logic             w_bp_hit;
    logic             w_lim_hit;
    logic             w_cpu_en;
    logic             w_dumping;
    logic             w_beat;
    logic             w_last_beat;
    logic [CNT_W:0]   w_cnt_inc;

    assign w_start_run = ((r_state == S_IDLE) || (r_state == S_HALT)) && i_start;

    assign w_bp_hit = (r_state == S_RUN) && !r_first_run && i_bp_en && (i_pc == i_bp_pc);

    // One extra bit keeps the compare correct when the counter has saturated.
    assign w_cnt_inc = {1'b0, r_cycle_count} + {{CNT_W{1'b0}}, 1'b1};
    assign w_lim_hit = (r_state == S_RUN) && !w_bp_hit && (i_cycle_limit != '0)
                     && (w_cnt_inc >= {1'b0, i_cycle_limit});

    assign w_cpu_en = ((r_state == S_RUN) && !w_bp_hit) || (r_state == S_STEP);

    assign w_dumping   = (r_state == S_DUMP_RF) || (r_state == S_DUMP_MEM);
    assign w_beat      = w_dumping && dump.dump_ready;
    assign w_last_beat = w_beat && (((r_state == S_DUMP_RF) && (r_dump_idx == c_RF_LAST))
                                 || ((r_state == S_DUMP_MEM) && (r_dump_idx == c_MEM_LAST)));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (i_start) begin
                    w_next_state = S_RUN;
                end else if (i_step) begin
                    w_next_state = S_STEP;
                end
            end
            S_RUN: begin
                if (w_bp_hit || w_lim_hit) begin
                    w_next_state = S_DUMP_RF;
                end
            end
            S_STEP: begin
                w_next_state = S_DUMP_RF;
            end
            S_DUMP_RF: begin
                if (w_last_beat) begin
                    w_next_state = S_DUMP_MEM;
                end
            end
            S_DUMP_MEM: begin
                if (w_last_beat) begin
                    w_next_state = S_HALT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cycle_count <= '0;
            r_dump_idx    <= '0;
            r_halt_cause  <= 2'b00;
            r_dump_done   <= 1'b0;
            r_first_run   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_first_run <= w_start_run;
            r_dump_done <= (r_state == S_DUMP_MEM) && w_last_beat;

            if (w_start_run) begin
                r_cycle_count <= '0;
            end else if (w_cpu_en && (r_cycle_count != c_CNT_MAX)) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end

            // The index restarts at 0 when a table completes, so the memory
            // walk starts at word 0 and the index rests at 0 in HALT.
            if (w_beat) begin
                if (w_last_beat) begin
                    r_dump_idx <= '0;
                end else begin
                    r_dump_idx <= r_dump_idx + 1'b1;
                end
            end

            if (w_bp_hit) begin
                r_halt_cause <= c_CAUSE_BP;
            end else if (w_lim_hit) begin
                r_halt_cause <= c_CAUSE_LIMIT;
            end else if (r_state == S_STEP) begin
                r_halt_cause <= c_CAUSE_STEP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_cpu_en      = w_cpu_en;
    assign o_rf_raddr    = (r_state == S_DUMP_RF)  ? r_dump_idx : '0;
    assign o_dm_raddr    = (r_state == S_DUMP_MEM) ? r_dump_idx : '0;
    assign o_cycle_count = r_cycle_count;
    assign o_halted      = (r_state == S_HALT);
    assign o_halt_cause  = r_halt_cause;

    // The core is stalled throughout the dump, so the combinational read
    // data stays stable while a beat waits for ready.
    assign dump.dump_valid  = w_dumping;
    assign dump.dump_is_mem = (r_state == S_DUMP_MEM);
    assign dump.dump_data   = (r_state == S_DUMP_MEM) ? i_dm_rdata : i_rf_rdata;
    assign dump.dump_idx    = r_dump_idx;
    assign dump.dump_done   = r_dump_done;

endmodule
`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_run_ctrl
// Description : Directed self-checking bench for proc_run_ctrl. It includes a
//               small PC model that advances by 4 on each enabled cycle,
//               preloaded register-file and data-memory arrays, and a second
//               instance with a 4-bit cycle counter for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, step;
    logic [15:0] cycle_limit;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic [31:0] pc;
    logic        cpu_en;
    logic [4:0]  rf_raddr, dm_raddr;
    logic [31:0] rf_rdata, dm_rdata;
    logic [15:0] cycle_count;
    logic        halted;
    logic [1:0]  halt_cause;

    logic [31:0] rf_mem [32];
    logic [31:0] dm_mem [8];

    // second instance, 4-bit counter
    logic        start2, step2;
    logic        cpu_en2, halted2;
    logic [4:0]  rf_raddr2, dm_raddr2;
    logic [3:0]  cycle_count2;
    logic [1:0]  halt_cause2;

    int n_checks = 0;
    int n_fail   = 0;

    proc_run_ctrl_if #(.REG_W(32), .IDX_W(5)) dif  ();
    proc_run_ctrl_if #(.REG_W(32), .IDX_W(5)) dif2 ();

    proc_run_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_step        (step),
        .i_cycle_limit (cycle_limit),
        .i_bp_en       (bp_en),
        .i_bp_pc       (bp_pc),
        .i_pc          (pc),
        .o_cpu_en      (cpu_en),
        .o_rf_raddr    (rf_raddr),
        .i_rf_rdata    (rf_rdata),
        .o_dm_raddr    (dm_raddr),
        .i_dm_rdata    (dm_rdata),
        .dump          (dif.master),
        .o_cycle_count (cycle_count),
        .o_halted      (halted),
        .o_halt_cause  (halt_cause)
    );

    proc_run_ctrl #(.CNT_W(4)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start2),
        .i_step        (step2),
        .i_cycle_limit (4'd0),
        .i_bp_en       (1'b0),
        .i_bp_pc       (32'h0),
        .i_pc          (32'h0),
        .o_cpu_en      (cpu_en2),
        .o_rf_raddr    (rf_raddr2),
        .i_rf_rdata    (32'h0),
        .o_dm_raddr    (dm_raddr2),
        .i_dm_rdata    (32'h0),
        .dump          (dif2.master),
        .o_cycle_count (cycle_count2),
        .o_halted      (halted2),
        .o_halt_cause  (halt_cause2)
    );

    assign dif2.dump_ready = 1'b1;
    assign rf_rdata = rf_mem[rf_raddr];
    assign dm_rdata = dm_mem[dm_raddr[2:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core PC model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc <= 32'h0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start or step and run until the first dump beat is valid.
    task automatic launch(input bit use_step, output int en_cyc,
                          output logic [31:0] first_pc, output logic [15:0] first_cnt);
        en_cyc = 0; first_pc = '0; first_cnt = '0;
        @(negedge clk);
        if (use_step) step = 1'b1; else start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = 1'b0; step = 1'b0;
            if (dif.dump_valid) break;
            if (cpu_en) begin
                if (en_cyc == 0) begin
                    first_pc  = pc;
                    first_cnt = cycle_count;
                end
                en_cyc++;
            end
        end
        chk("launch_reaches_dump", dif.dump_valid, 1);
    endtask

    // Consume the 40-beat dump, starting at the negedge of the first valid beat.
    task automatic collect(input bit toggle);
        int          beats = 0, done_cnt = 0, done_at = -1, last_at = -100;
        logic        prev_stall = 1'b0;
        logic [4:0]  prev_idx = '0;
        logic [31:0] prev_data = '0;
        logic        prev_mem = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            dif.dump_ready = toggle ? c[0] : 1'b1;
            if (prev_stall) begin
                chk("stall_valid", dif.dump_valid, 1);
                chk("stall_idx", dif.dump_idx, prev_idx);
                chk("stall_data", dif.dump_data, prev_data);
                chk("stall_is_mem", dif.dump_is_mem, prev_mem);
            end
            if (dif.dump_valid && dif.dump_ready) begin
                if (beats < 32) begin
                    chk($sformatf("beat%0d_is_mem", beats), dif.dump_is_mem, 0);
                    chk($sformatf("beat%0d_idx", beats), dif.dump_idx, beats);
                    chk($sformatf("beat%0d_data", beats), dif.dump_data, rf_mem[beats]);
                end else begin
                    chk($sformatf("beat%0d_is_mem", beats), dif.dump_is_mem, 1);
                    chk($sformatf("beat%0d_idx", beats), dif.dump_idx, beats - 32);
                    chk($sformatf("beat%0d_data", beats), dif.dump_data, dm_mem[(beats-32) % 8]);
                end
                beats++;
                if (beats == 40) last_at = c;
            end
            if (dif.dump_done) begin
                done_cnt++;
                done_at = c;
            end
            prev_stall = dif.dump_valid && !dif.dump_ready;
            prev_idx   = dif.dump_idx;
            prev_data  = dif.dump_data;
            prev_mem   = dif.dump_is_mem;
            if (beats >= 40 && c >= last_at + 3) break;
        end
        chk("dump_beats", beats, 40);
        chk("dump_done_pulses", done_cnt, 1);
        chk("dump_done_timing", done_at, last_at + 1);
        chk("halted_after_dump", halted, 1);
        chk("valid_after_dump", dif.dump_valid, 0);
        dif.dump_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int          en;
    logic [31:0] fpc;
    logic [15:0] fcnt;

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA500_0000 | i;
        rf_mem[0] = 32'd0;
        rf_mem[1] = 32'd10;
        rf_mem[2] = 32'd20;
        for (int i = 0; i < 8; i++) dm_mem[i] = 32'hD000_0000 | (i * 3);

        rst_n = 1'b0; start = 0; step = 0; start2 = 0; step2 = 0;
        cycle_limit = 16'd0; bp_en = 0; bp_pc = 32'h0;
        dif.dump_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_valid", dif.dump_valid, 0);
        chk("rst_done", dif.dump_done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_is_mem", dif.dump_is_mem, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_idx", dif.dump_idx, 0);
        chk("rst_cause", halt_cause, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Limit run
        cycle_limit = 16'd5;
        launch(1'b0, en, fpc, fcnt);
        chk("t1_en_cycles", en, 5);
        chk("t1_count", cycle_count, 5);
        chk("t1_cause", halt_cause, 2'b01);
        collect(1'b0);
        chk("t1_halt_cause", halt_cause, 2'b01);
        chk("t1_rf_raddr_idle", rf_raddr, 0);

        // 2. Backpressure
        launch(1'b0, en, fpc, fcnt);
        chk("t2_en_cycles", en, 5);
        chk("t2_first_cnt", fcnt, 0);
        collect(1'b1);
        chk("t2_count", cycle_count, 5);

        // 3. Breakpoint
        do_reset();
        cycle_limit = 16'd0; bp_en = 1'b1; bp_pc = 32'h0C;
        launch(1'b0, en, fpc, fcnt);
        chk("t3_en_cycles", en, 3);
        chk("t3_first_pc", fpc, 32'h0);
        chk("t3_pc_at_halt", pc, 32'h0C);
        chk("t3_count", cycle_count, 3);
        chk("t3_cause", halt_cause, 2'b10);
        collect(1'b0);

        // 4. Step from HALT
        launch(1'b1, en, fpc, fcnt);
        chk("t4_en_cycles", en, 1);
        chk("t4_pc", pc, 32'h10);
        chk("t4_count", cycle_count, 4);
        chk("t4_cause", halt_cause, 2'b11);
        collect(1'b0);

        // 4b. Resume from the breakpoint address: no immediate re-trap
        bp_pc = 32'h10; cycle_limit = 16'd2;
        launch(1'b0, en, fpc, fcnt);
        chk("t4b_first_pc", fpc, 32'h10);
        chk("t4b_first_cnt", fcnt, 0);
        chk("t4b_en_cycles", en, 2);
        chk("t4b_count", cycle_count, 2);
        chk("t4b_cause", halt_cause, 2'b01);
        collect(1'b0);
        bp_en = 1'b0;

        // 5. Reset mid-dump
        cycle_limit = 16'd5;
        launch(1'b0, en, fpc, fcnt);
        dif.dump_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (dif.dump_idx == 5'd10) break;
            @(negedge clk);
        end
        chk("t5_idx_reached", dif.dump_idx, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", dif.dump_valid, 0);
        chk("t5_async_cpu_en", cpu_en, 0);
        chk("t5_async_count", cycle_count, 0);
        chk("t5_async_idx", dif.dump_idx, 0);
        chk("t5_async_cause", halt_cause, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_idle_cpu_en", cpu_en, 0);
        chk("t5_idle_valid", dif.dump_valid, 0);
        chk("t5_idle_halted", halted, 0);
        cycle_limit = 16'd3;
        launch(1'b0, en, fpc, fcnt);
        chk("t5_en_cycles", en, 3);
        chk("t5_count", cycle_count, 3);
        collect(1'b0);

        // 6. Simultaneous start/step, then counter saturation
        @(negedge clk);
        start2 = 1'b1; step2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; step2 = 1'b0;
        chk("t6_run_entered", cpu_en2, 1);
        @(negedge clk);
        chk("t6_still_running", cpu_en2, 1);
        chk("t6_no_dump", dif2.dump_valid, 0);
        for (int c = 0; c < 20; c++) @(negedge clk);
        chk("t6_sat_count", cycle_count2, 4'd15);
        chk("t6_sat_cpu_en", cpu_en2, 1);
        chk("t6_cause", halt_cause2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
